// File: rtl/emissor.sv
// emissor: pulse-width-coded IR frame transmitter.
// A frame is a leader pulse, 32 data pulses (address, ~address, key, ~key,
// each LSB first) and a stop pulse. A data bit's value is carried by the
// width of its high pulse. Every pulse is followed by a GAP_LOW low time.
module emissor #(
    parameter int          ZERO_HIGH = 23000,
    parameter int          ONE_HIGH  = 79000,
    parameter int          LEAD_HIGH = 158000,
    parameter int          STOP_HIGH = 23000,
    parameter int          GAP_LOW   = 23000,
    parameter logic [7:0]  ADDRESS   = 8'h00,
    parameter int          CW        = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] keyCode,
    output logic       sinal,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [5:0]    LAST_IDX = 6'd33;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LOW - 1);

    state_t        state;
    logic [5:0]    idx;
    logic [CW-1:0] counter;
    logic [7:0]    key;
    logic [CW-1:0] high_last;

    // Bit carried by data pulse i (1..32): byte (i-1)/8, bit (i-1)%8.
    function automatic logic pulse_bit(input logic [5:0] i, input logic [7:0] k);
        logic [5:0] t;
        logic [7:0] addr;
        t    = i - 6'd1;
        addr = ADDRESS;
        case (t[4:3])
            2'd0:    return addr[t[2:0]];
            2'd1:    return ~addr[t[2:0]];
            2'd2:    return k[t[2:0]];
            default: return ~k[t[2:0]];
        endcase
    endfunction

    // High-phase width of pulse i: leader, stop, or a data bit.
    function automatic logic [CW-1:0] pulse_width(input logic [5:0] i, input logic [7:0] k);
        if (i == 6'd0)
            return CW'(LEAD_HIGH);
        else if (i == LAST_IDX)
            return CW'(STOP_HIGH);
        else if (pulse_bit(i, k))
            return CW'(ONE_HIGH);
        else
            return CW'(ZERO_HIGH);
    endfunction

    // Last counter value of the current high phase.
    assign high_last = pulse_width(idx, key) - CW'(1);

    // Frame sequencer: outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 6'd0;
            counter <= '0;
            key     <= 8'h00;
            sinal   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key     <= keyCode;
                        idx     <= 6'd0;
                        counter <= '0;
                        state   <= HIGH;
                        sinal   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                HIGH: begin
                    if (counter == high_last) begin
                        counter <= '0;
                        state   <= LOW;
                        sinal   <= 1'b0;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                LOW: begin
                    if (counter == GAP_LAST) begin
                        counter <= '0;
                        if (idx == LAST_IDX) begin
                            idx   <= 6'd0;
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= HIGH;
                            sinal <= 1'b1;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    sinal <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/emissor.md
# emissor

Pulse-width-coded infrared frame transmitter, the sending end of the link decoded by the key-code receiver. On a start request it captures an 8-bit key code and drives `sinal` with a 34-pulse frame: a leader pulse, 32 data pulses, and a stop pulse. The data pulses carry address, inverted address, key code and inverted key code, LSB first, and each data bit's value is set by the width of its high pulse. It sits between the keypad/control logic and the IR LED driver, and also serves as the stimulus generator for receiver tests.

## Interface
- `ZERO_HIGH`, 23000: high width, in clk cycles, of a data bit 0.
- `ONE_HIGH`, 79000: high width of a data bit 1.
- `LEAD_HIGH`, 158000: high width of the leader pulse.
- `STOP_HIGH`, 23000: high width of the stop pulse.
- `GAP_LOW`, 23000: low time after every pulse, including the stop pulse.
- `ADDRESS`, 8'h00: device address sent in every frame.
- `CW`, 18: width of the cycle counter. Every width parameter is ≥1 and ≤ 2^CW−1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled only while idle.
- `keyCode`  in  8  key code; captured on the edge that accepts `start`.
- `sinal`  out  1  IR envelope. Idle low; high = carrier on.
- `busy`  out  1  high for the whole frame.
- `done`  out  1  one-cycle pulse when the frame completes.

## Operation
- States:
  - IDLE: `sinal`=0, `busy`=0.
  - HIGH: `sinal`=1.
  - LOW: `sinal`=0.
- Pulse index `idx` runs 0..33:
  - idx 0: leader, width LEAD_HIGH.
  - idx 1–8: ADDRESS[0..7].
  - idx 9–16: ~ADDRESS[0..7].
  - idx 17–24: keyCode[0..7].
  - idx 25–32: ~keyCode[0..7].
  - idx 33: stop, width STOP_HIGH.
- A data pulse has width ONE_HIGH if its bit is 1, otherwise ZERO_HIGH.
- IDLE → HIGH when `start`=1 at an edge:
  - latch `keyCode` into an internal 8-bit register;
  - set idx=0 and counter=0.
- HIGH:
  - counter increments each cycle;
  - when counter reaches width−1: → LOW, counter=0.
- LOW:
  - counter increments each cycle;
  - when counter reaches GAP_LOW−1 and idx<33: → HIGH, idx+1, counter=0;
  - when counter reaches GAP_LOW−1 and idx=33: → IDLE, `done`=1 for one cycle.
- `start` during HIGH/LOW is ignored. Changes on `keyCode` during a frame have no effect.
- Every frame carries exactly 16 one-bits and 16 zero-bits, so frame length is independent of data.
  - Length = LEAD_HIGH + STOP_HIGH + 16·(ZERO_HIGH+ONE_HIGH) + 34·GAP_LOW cycles.
  - With default parameters this is 2 595 000 cycles.
- Counter never wraps: widths are bounded by 2^CW−1. Comparisons are at CW bits.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `sinal`=0, `busy`=0, `done`=0;
  - state IDLE, idx=0, counter=0, latched key=0.
  - This applies mid-frame too: `sinal` drops low immediately, without waiting for a clk edge.
- Start edge E (`start`=1 while idle): from E onward `busy`=1 and `sinal`=1. Latency is 1 edge, outputs registered.
- Pulse k's high phase lasts exactly its width in cycles, then `sinal` is low for exactly GAP_LOW cycles.
- `done` is asserted on the same edge that `busy` falls, and is 0 on the following edge.
- `start` held high continuously: the next frame begins one cycle after `done`, with 1 idle cycle between frames.
- `start` re-asserted in the same cycle that `done` is high is not accepted. Acceptance happens on the next edge.
- `rst_n` released with `start`=1: the first frame begins at the first rising edge after release.

## Test plan
Scenarios 1–5 use test parameters ZERO_HIGH=2, ONE_HIGH=5, LEAD_HIGH=8, STOP_HIGH=2, GAP_LOW=2, ADDRESS=8'hA5. Frame length for these parameters is 190 cycles.

1. Reset then idle, `start`=0 for 50 cycles → `sinal`=0, `busy`=0, `done`=0 throughout.
2. `start` pulse with keyCode=8'h3C:
   - high-pulse widths in order: 8; A5 LSB-first (5,2,5,2,2,5,2,5); inverse; 3C LSB-first (2,2,5,5,5,5,2,2); inverse; stop 2.
   - every low gap is 2 cycles;
   - `busy` is high for 190 cycles;
   - `done` is a single pulse.
3. keyCode changed to 8'hFF and `start` pulsed again at cycle 40 of a frame → frame still carries 8'h3C; no second frame follows.
4. `start` held high for 500 cycles → two complete frames, each 190 cycles long, separated by 1 idle cycle. A third frame starts at cycle 382.
5. `rst_n` asserted at cycle 100 of a frame, during a high pulse → `sinal` and `busy` go low asynchronously; `done` is never pulsed. A new `start` after release produces a full, correct frame.
6. Default parameters, keyCode=8'h00:
   - leader high is 158000 cycles;
   - data bit 17 (keyCode bit 0) high is 23000 cycles;
   - data bit 25 (~keyCode bit 0) high is 79000 cycles;
   - total frame is 2 595 000 cycles.
